// File: rtl/router_link_pipe.sv
// router_link_pipe: multi-port link retiming stage between a VC router core and
// its network links. Every flit and credit path goes through num_stages register
// stages. On the outgoing network side it shadows the downstream per-VC credit
// count and raises sticky per-port error flags on credit underflow or overflow.
// Define ROUTER_LINK_PIPE_PKT_CHECK_EN to add per-(port, VC) head/tail framing checks.

// Valid-qualified delay line. The valid bit is the MSB of the word. The payload
// flops load only on valid beats, so idle cycles do not toggle the data path.
module router_link_pipe_stage #(
    parameter int width      = 8,
    parameter int num_stages = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] in_word,
    output logic [width-1:0] out_word
);
    generate
        if (num_stages == 0) begin : g_bypass
            assign out_word = in_word;
        end else begin : g_pipe
            logic             valid_q   [num_stages];
            logic [width-2:0] payload_q [num_stages];

            // Shift valid every cycle; move payload only together with a valid beat
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < num_stages; s++) begin
                        valid_q[s]   <= 1'b0;
                        payload_q[s] <= '0;
                    end
                end else begin
                    valid_q[0] <= in_word[width-1];
                    if (in_word[width-1]) begin
                        payload_q[0] <= in_word[width-2:0];
                    end
                    for (int s = 1; s < num_stages; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        if (valid_q[s-1]) begin
                            payload_q[s] <= payload_q[s-1];
                        end
                    end
                end
            end

            assign out_word = {valid_q[num_stages-1], payload_q[num_stages-1]};
        end
    endgenerate
endmodule

module router_link_pipe #(
    parameter int num_ports       = 5,
    parameter int num_vcs         = 4,
    parameter int vc_idx_width    = 2,
    parameter int flit_data_width = 64,
    parameter int num_stages      = 1,
    parameter int buffer_size     = 8,
    parameter int channel_width   = flit_data_width + vc_idx_width + 3,
    parameter int flow_ctrl_width = vc_idx_width + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [num_ports*channel_width-1:0]   rtr_channel_out_op,
    output logic [num_ports*channel_width-1:0]   net_channel_out_op,
    input  logic [num_ports*flow_ctrl_width-1:0] net_flow_ctrl_in_op,
    output logic [num_ports*flow_ctrl_width-1:0] rtr_flow_ctrl_in_op,
    input  logic [num_ports*channel_width-1:0]   net_channel_in_ip,
    output logic [num_ports*channel_width-1:0]   rtr_channel_in_ip,
    input  logic [num_ports*flow_ctrl_width-1:0] rtr_flow_ctrl_out_ip,
    output logic [num_ports*flow_ctrl_width-1:0] net_flow_ctrl_out_ip,
    output logic [num_ports-1:0]                 error_op,
    output logic                                 error
);
    localparam int cnt_width = $clog2(buffer_size + 1);
    localparam int vld_bit   = channel_width - 1;
    localparam int vc_lsb    = flit_data_width + 2;
    localparam int fc_vld    = flow_ctrl_width - 1;
    localparam logic [cnt_width-1:0] cnt_full = cnt_width'(buffer_size);

    // Per-(port, VC) decode of the beats seen at the network side of the outgoing path
    logic [num_vcs-1:0] flit_hit [num_ports];
    logic [num_vcs-1:0] cred_hit [num_ports];

    genvar gp, gv;
    generate
        for (gp = 0; gp < num_ports; gp++) begin : g_port
            router_link_pipe_stage #(.width(channel_width), .num_stages(num_stages)) u_flit_out (
                .clk      (clk),
                .reset    (reset),
                .in_word  (rtr_channel_out_op[gp*channel_width +: channel_width]),
                .out_word (net_channel_out_op[gp*channel_width +: channel_width])
            );
            router_link_pipe_stage #(.width(flow_ctrl_width), .num_stages(num_stages)) u_cred_in (
                .clk      (clk),
                .reset    (reset),
                .in_word  (net_flow_ctrl_in_op[gp*flow_ctrl_width +: flow_ctrl_width]),
                .out_word (rtr_flow_ctrl_in_op[gp*flow_ctrl_width +: flow_ctrl_width])
            );
            router_link_pipe_stage #(.width(channel_width), .num_stages(num_stages)) u_flit_in (
                .clk      (clk),
                .reset    (reset),
                .in_word  (net_channel_in_ip[gp*channel_width +: channel_width]),
                .out_word (rtr_channel_in_ip[gp*channel_width +: channel_width])
            );
            router_link_pipe_stage #(.width(flow_ctrl_width), .num_stages(num_stages)) u_cred_out (
                .clk      (clk),
                .reset    (reset),
                .in_word  (rtr_flow_ctrl_out_ip[gp*flow_ctrl_width +: flow_ctrl_width]),
                .out_word (net_flow_ctrl_out_ip[gp*flow_ctrl_width +: flow_ctrl_width])
            );

            for (gv = 0; gv < num_vcs; gv++) begin : g_vc
                assign flit_hit[gp][gv] = net_channel_out_op[gp*channel_width + vld_bit] &&
                    (net_channel_out_op[gp*channel_width + vc_lsb +: vc_idx_width] == vc_idx_width'(gv));
                assign cred_hit[gp][gv] = net_flow_ctrl_in_op[gp*flow_ctrl_width + fc_vld] &&
                    (net_flow_ctrl_in_op[gp*flow_ctrl_width +: vc_idx_width] == vc_idx_width'(gv));
            end
        end
    endgenerate

    logic [cnt_width-1:0] credit_cnt      [num_ports][num_vcs];
    logic [cnt_width-1:0] credit_cnt_next [num_ports][num_vcs];
    logic [num_ports-1:0] credit_err;
    logic [num_ports-1:0] pkt_err;

    // Credit shadow update: flit consumes, credit returns, both at once cancel; saturate on violations
    always_comb begin
        credit_err = '0;
        for (int p = 0; p < num_ports; p++) begin
            for (int v = 0; v < num_vcs; v++) begin
                credit_cnt_next[p][v] = credit_cnt[p][v];
                if (flit_hit[p][v] && cred_hit[p][v]) begin
                    credit_cnt_next[p][v] = credit_cnt[p][v];
                end else if (flit_hit[p][v]) begin
                    if (credit_cnt[p][v] == '0) begin
                        credit_err[p] = 1'b1;
                    end else begin
                        credit_cnt_next[p][v] = credit_cnt[p][v] - cnt_width'(1);
                    end
                end else if (cred_hit[p][v]) begin
                    if (credit_cnt[p][v] == cnt_full) begin
                        credit_err[p] = 1'b1;
                    end else begin
                        credit_cnt_next[p][v] = credit_cnt[p][v] + cnt_width'(1);
                    end
                end
            end
        end
    end

    // Credit counters start full: the downstream buffers are empty after a joint reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < num_ports; p++) begin
                for (int v = 0; v < num_vcs; v++) begin
                    credit_cnt[p][v] <= cnt_full;
                end
            end
        end else begin
            for (int p = 0; p < num_ports; p++) begin
                for (int v = 0; v < num_vcs; v++) begin
                    credit_cnt[p][v] <= credit_cnt_next[p][v];
                end
            end
        end
    end

`ifdef ROUTER_LINK_PIPE_PKT_CHECK_EN
    typedef enum logic {
        PKT_IDLE   = 1'b0,
        PKT_ACTIVE = 1'b1
    } pkt_state_t;

    pkt_state_t           pkt_state      [num_ports][num_vcs];
    pkt_state_t           pkt_state_next [num_ports][num_vcs];
    logic [num_ports-1:0] flit_head;
    logic [num_ports-1:0] flit_tail;

    generate
        for (gp = 0; gp < num_ports; gp++) begin : g_ht
            assign flit_head[gp] = net_channel_out_op[gp*channel_width + flit_data_width + 1];
            assign flit_tail[gp] = net_channel_out_op[gp*channel_width + flit_data_width];
        end
    endgenerate

    // Packet state register per (port, VC)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < num_ports; p++) begin
                for (int v = 0; v < num_vcs; v++) begin
                    pkt_state[p][v] <= PKT_IDLE;
                end
            end
        end else begin
            for (int p = 0; p < num_ports; p++) begin
                for (int v = 0; v < num_vcs; v++) begin
                    pkt_state[p][v] <= pkt_state_next[p][v];
                end
            end
        end
    end

    // Next state: a stray body flit in IDLE is ignored, otherwise the tail bit decides
    always_comb begin
        for (int p = 0; p < num_ports; p++) begin
            for (int v = 0; v < num_vcs; v++) begin
                pkt_state_next[p][v] = pkt_state[p][v];
                if (flit_hit[p][v] && (pkt_state[p][v] == PKT_ACTIVE || flit_head[p])) begin
                    pkt_state_next[p][v] = flit_tail[p] ? PKT_IDLE : PKT_ACTIVE;
                end
            end
        end
    end

    // Framing errors: body flit outside a packet, or a new head inside one
    always_comb begin
        pkt_err = '0;
        for (int p = 0; p < num_ports; p++) begin
            for (int v = 0; v < num_vcs; v++) begin
                if (flit_hit[p][v] &&
                    ((pkt_state[p][v] == PKT_IDLE   && !flit_head[p]) ||
                     (pkt_state[p][v] == PKT_ACTIVE &&  flit_head[p]))) begin
                    pkt_err[p] = 1'b1;
                end
            end
        end
    end
`else
    assign pkt_err = '0;
`endif

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_op <= '0;
        end else begin
            error_op <= error_op | credit_err | pkt_err;
        end
    end

    assign error = |error_op;
endmodule

// File: tb/tb_router_link_pipe.sv
// tb_router_link_pipe: directed bench for router_link_pipe (num_stages=2, buffer_size=8).
// Stimulus tasks push expected beats into per-path queues; a negedge monitor pops and
// compares them when the DUT presents a valid output. Error flags are checked directly.
// The framing test runs only when ROUTER_LINK_PIPE_PKT_CHECK_EN is defined.

module tb_router_link_pipe;
    localparam int NP = 5;
    localparam int NV = 4;
    localparam int VW = 2;
    localparam int DW = 64;
    localparam int ST = 2;
    localparam int BS = 8;
    localparam int CW = DW + VW + 3;
    localparam int FW = VW + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*CW-1:0]  rtr_channel_out_op;
    logic [NP*CW-1:0]  net_channel_out_op;
    logic [NP*FW-1:0]  net_flow_ctrl_in_op;
    logic [NP*FW-1:0]  rtr_flow_ctrl_in_op;
    logic [NP*CW-1:0]  net_channel_in_ip;
    logic [NP*CW-1:0]  rtr_channel_in_ip;
    logic [NP*FW-1:0]  rtr_flow_ctrl_out_ip;
    logic [NP*FW-1:0]  net_flow_ctrl_out_ip;
    logic [NP-1:0]     error_op;
    logic              error;

    typedef struct {
        int            port;
        logic [CW-1:0] word;
        int            due;
    } exp_t;

    exp_t        exp_q [4][$];
    string       path_name [4] = '{"net_flit_out", "rtr_credit_in", "rtr_flit_in", "net_credit_out"};
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [NP-1:0] exp_err = '0;

    router_link_pipe #(
        .num_ports       (NP),
        .num_vcs         (NV),
        .vc_idx_width    (VW),
        .flit_data_width (DW),
        .num_stages      (ST),
        .buffer_size     (BS)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .rtr_channel_out_op   (rtr_channel_out_op),
        .net_channel_out_op   (net_channel_out_op),
        .net_flow_ctrl_in_op  (net_flow_ctrl_in_op),
        .rtr_flow_ctrl_in_op  (rtr_flow_ctrl_in_op),
        .net_channel_in_ip    (net_channel_in_ip),
        .rtr_channel_in_ip    (rtr_channel_in_ip),
        .rtr_flow_ctrl_out_ip (rtr_flow_ctrl_out_ip),
        .net_flow_ctrl_out_ip (net_flow_ctrl_out_ip),
        .error_op             (error_op),
        .error                (error)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected beats
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [CW-1:0] out_word(input int path, input int port);
        case (path)
            0:       return net_channel_out_op[port*CW +: CW];
            1:       return CW'(rtr_flow_ctrl_in_op[port*FW +: FW]);
            2:       return rtr_channel_in_ip[port*CW +: CW];
            default: return CW'(net_flow_ctrl_out_ip[port*FW +: FW]);
        endcase
    endfunction

    // Monitor: every valid output beat must match the oldest expected beat of its path
    always @(negedge clk) begin
        logic [CW-1:0] w;
        logic          vld;
        exp_t          e;
        if (reset) begin
            for (int path = 0; path < 4; path++) begin
                for (int port = 0; port < NP; port++) begin
                    w   = out_word(path, port);
                    vld = (path % 2 == 0) ? w[CW-1] : w[FW-1];
                    if (vld) begin
                        checks++;
                        if (exp_q[path].size() == 0) begin
                            errors++;
                            $display("[TB] FAIL %s unexpected beat: port %0d word %0h cycle %0d, required no beat",
                                     path_name[path], port, w, cycle);
                        end else begin
                            e = exp_q[path].pop_front();
                            if (e.port != port || e.word !== w || e.due != cycle) begin
                                errors++;
                                $display("[TB] FAIL %s: got port %0d word %0h cycle %0d, required port %0d word %0h cycle %0d",
                                         path_name[path], port, w, cycle, e.port, e.word, e.due);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic check_errors(input string name);
        check_output({name, "_error_op"}, 64'(error_op), 64'(exp_err));
        check_output({name, "_error"}, 64'(error), 64'(|exp_err));
    endtask

    task automatic clear_inputs();
        rtr_channel_out_op   = '0;
        net_flow_ctrl_in_op  = '0;
        net_channel_in_ip    = '0;
        rtr_flow_ctrl_out_ip = '0;
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            clear_inputs();
        end
    endtask

    task automatic push_exp(input int path, input int port, input logic [CW-1:0] w);
        exp_t e;
        e.port = port;
        e.word = w;
        e.due  = cycle + ST;
        exp_q[path].push_back(e);
    endtask

    task automatic apply_flit_out(input int port, input int vc, input bit head, input bit tail, input logic [DW-1:0] data);
        logic [CW-1:0] w;
        w = {1'b1, VW'(vc), head, tail, data};
        rtr_channel_out_op[port*CW +: CW] = w;
        push_exp(0, port, w);
    endtask

    task automatic apply_credit_in(input int port, input int vc);
        logic [FW-1:0] w;
        w = {1'b1, VW'(vc)};
        net_flow_ctrl_in_op[port*FW +: FW] = w;
        push_exp(1, port, CW'(w));
    endtask

    task automatic apply_flit_in(input int port, input int vc, input bit head, input bit tail, input logic [DW-1:0] data);
        logic [CW-1:0] w;
        w = {1'b1, VW'(vc), head, tail, data};
        net_channel_in_ip[port*CW +: CW] = w;
        push_exp(2, port, w);
    endtask

    task automatic apply_credit_out(input int port, input int vc);
        logic [FW-1:0] w;
        w = {1'b1, VW'(vc)};
        rtr_flow_ctrl_out_ip[port*FW +: FW] = w;
        push_exp(3, port, CW'(w));
    endtask

    task automatic check_pipe_outputs_zero(input string name);
        check_output({name, "_net_flit_out"}, 64'(|net_channel_out_op), 64'd0);
        check_output({name, "_rtr_credit_in"}, 64'(|rtr_flow_ctrl_in_op), 64'd0);
        check_output({name, "_rtr_flit_in"}, 64'(|rtr_channel_in_ip), 64'd0);
        check_output({name, "_net_credit_out"}, 64'(|net_flow_ctrl_out_ip), 64'd0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        check_pipe_outputs_zero("reset");
        check_errors("reset");
        reset = 1'b1;
        step();

        // Latency: single-flit packet at cycle 10 appears at cycle 12
        $display("[TB] latency test");
        while (cycle < 10) step();
        apply_flit_out(3, 1, 1'b1, 1'b1, 64'hA5);
        step();
        check_output("idle_cycle_valid", 64'(net_channel_out_op[3*CW + CW - 1]), 64'd0);
        step(3);
        check_errors("latency");

        // Exhaust port 0 VC 2 credits, then one flit too many
        $display("[TB] credit underflow test");
        for (int i = 0; i < BS; i++) begin
            apply_flit_out(0, 2, 1'b1, 1'b1, 64'(i) + 64'h100);
            step();
        end
        step(4);
        check_errors("eight_flits");
        apply_flit_out(0, 2, 1'b1, 1'b1, 64'hDEAD);
        step(2);
        check_errors("ninth_flit_in_flight");
        step();
        exp_err[0] = 1'b1;
        check_errors("ninth_flit");

`ifdef ROUTER_LINK_PIPE_PKT_CHECK_EN
        // Framing: second head inside a packet, and a body flit on an idle VC
        $display("[TB] packet framing test");
        apply_flit_out(4, 0, 1'b1, 1'b0, 64'h40);
        step();
        apply_flit_out(4, 0, 1'b1, 1'b0, 64'h41);
        step(4);
        exp_err[4] = 1'b1;
        check_errors("double_head");
        apply_flit_out(1, 1, 1'b0, 1'b1, 64'h11);
        step(4);
        exp_err[1] = 1'b1;
        check_errors("body_in_idle");
`endif

        // Credit returned with a full counter
        $display("[TB] credit overflow test");
        apply_credit_in(1, 0);
        step();
        exp_err[1] = 1'b1;
        check_errors("credit_overflow");
        step(3);

        // Port 2 VC 3 at zero: flit and credit together keep it at zero without error
        $display("[TB] simultaneous flit and credit test");
        for (int i = 0; i < BS; i++) begin
            apply_flit_out(2, 3, 1'b1, 1'b1, 64'(i) + 64'h200);
            step();
        end
        step(3);
        apply_flit_out(2, 3, 1'b1, 1'b1, 64'h2F0);
        step(2);
        apply_credit_in(2, 3);
        step(4);
        check_errors("flit_and_credit_at_zero");
        apply_flit_out(2, 3, 1'b1, 1'b1, 64'h2F1);
        step(4);
        exp_err[2] = 1'b1;
        check_errors("counter_held_zero");

        // Incoming direction on all ports in one cycle, then credits outward
        $display("[TB] incoming path test");
        for (int p = 0; p < NP; p++) apply_flit_in(p, p % NV, 1'b1, 1'b0, 64'hC0DE_0000 + 64'(p));
        step();
        for (int p = 0; p < NP; p++) apply_credit_out(p, (p + 1) % NV);
        step();
        apply_flit_in(2, 1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(4);
        check_errors("incoming_no_checks");

        // Reset with flits in flight: outputs drop immediately, counters refill
        $display("[TB] mid-packet reset test");
        apply_flit_out(3, 0, 1'b1, 1'b0, 64'h31);
        step();
        apply_flit_out(3, 0, 1'b0, 1'b0, 64'h32);
        step();
        apply_flit_out(3, 0, 1'b0, 1'b1, 64'h33);
        check_output("pre_reset_valid", 64'(net_channel_out_op[3*CW + CW - 1]), 64'd1);
        #1;
        reset = 1'b0;
        clear_inputs();
        for (int path = 0; path < 4; path++) exp_q[path].delete();
        #1;
        exp_err = '0;
        check_pipe_outputs_zero("in_reset");
        check_errors("in_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(4);
        check_pipe_outputs_zero("after_reset");
        check_errors("after_reset");
        apply_credit_in(3, 1);
        step();
        exp_err[3] = 1'b1;
        check_errors("counter_refilled");

        step(ST + 3);
        check_output("scoreboard_drained", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
